// File: rtl/axi4_burst_master.sv
// Single-outstanding AXI4 INCR burst master: one command becomes one AW/AR burst with W/R beats streamed through.
// AW/AR issue 1 cycle after accept; beats pass combinationally under wr_t*/rd_t* and slave backpressure; cmd_ready only when idle.
module axi4_burst_master #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int TXN_ID     = 0
) (
    input  logic                      axi_aclk,
    input  logic                      axi_areset,

    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [7:0]                cmd_len,

    input  logic                      wr_tvalid,
    output logic                      wr_tready,
    input  logic [DATA_WIDTH-1:0]     wr_tdata,

    output logic                      rd_tvalid,
    input  logic                      rd_tready,
    output logic [DATA_WIDTH-1:0]     rd_tdata,
    output logic                      rd_tlast,

    output logic                      done,
    output logic [1:0]                done_resp,

    output logic [ID_WIDTH-1:0]       m_axi_awid,
    output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [7:0]                m_axi_awlen,
    output logic [2:0]                m_axi_awsize,
    output logic [1:0]                m_axi_awburst,
    output logic                      m_axi_awlock,
    output logic [3:0]                m_axi_awcache,
    output logic [2:0]                m_axi_awprot,
    output logic [3:0]                m_axi_awqos,
    output logic [3:0]                m_axi_awregion,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,

    output logic [DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                      m_axi_wlast,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,

    input  logic [ID_WIDTH-1:0]       m_axi_bid,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,

    output logic [ID_WIDTH-1:0]       m_axi_arid,
    output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [7:0]                m_axi_arlen,
    output logic [2:0]                m_axi_arsize,
    output logic [1:0]                m_axi_arburst,
    output logic                      m_axi_arlock,
    output logic [3:0]                m_axi_arcache,
    output logic [2:0]                m_axi_arprot,
    output logic [3:0]                m_axi_arqos,
    output logic [3:0]                m_axi_arregion,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,

    input  logic [ID_WIDTH-1:0]       m_axi_rid,
    input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rlast,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int SIZE  = $clog2(BYTES);

    typedef enum logic [2:0] {IDLE, ADDR, WDATA, WRESP, RDATA, DONE} state_t;

    state_t                  state;
    logic                    write_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [7:0]              len_q;
    logic [7:0]              beat_cnt;
    logic [1:0]              resp_q;
    logic                    aw_vld_q;
    logic                    ar_vld_q;
    logic                    done_q;

    logic [23:0]             burst_end;
    logic                    crosses_4k;
    logic                    rd_len_err;
    logic [1:0]              rd_resp_nxt;
    logic                    unused_ids;

    function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Last byte of the burst must stay inside the 4 KB page of the start address.
    assign burst_end  = {12'd0, cmd_addr[11:0]} + (({16'd0, cmd_len}) + 24'd1) * 24'(BYTES);
    assign crosses_4k = burst_end > 24'd4096;

    // A length mismatch in either direction (early rlast, or no rlast on the final beat) is reported as SLVERR.
    assign rd_len_err = m_axi_rlast != (beat_cnt == len_q);

    always_comb begin
        rd_resp_nxt = worst(resp_q, m_axi_rresp);
        if (rd_len_err) begin
            rd_resp_nxt = worst(rd_resp_nxt, 2'b10);
        end
    end

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            state    <= IDLE;
            write_q  <= 1'b0;
            addr_q   <= '0;
            len_q    <= 8'd0;
            beat_cnt <= 8'd0;
            resp_q   <= 2'b00;
            aw_vld_q <= 1'b0;
            ar_vld_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        write_q  <= cmd_write;
                        addr_q   <= cmd_addr;
                        len_q    <= cmd_len;
                        beat_cnt <= 8'd0;
                        if (crosses_4k) begin
                            resp_q <= 2'b10;
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else begin
                            resp_q   <= 2'b00;
                            aw_vld_q <= cmd_write;
                            ar_vld_q <= !cmd_write;
                            state    <= ADDR;
                        end
                    end
                end
                ADDR: begin
                    if (write_q && m_axi_awready) begin
                        aw_vld_q <= 1'b0;
                        state    <= WDATA;
                    end else if (!write_q && m_axi_arready) begin
                        ar_vld_q <= 1'b0;
                        state    <= RDATA;
                    end
                end
                WDATA: begin
                    if (wr_tvalid && m_axi_wready) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        if (beat_cnt == len_q) begin
                            state <= WRESP;
                        end
                    end
                end
                WRESP: begin
                    if (m_axi_bvalid) begin
                        resp_q <= worst(resp_q, m_axi_bresp);
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                RDATA: begin
                    if (m_axi_rvalid && rd_tready) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        resp_q   <= rd_resp_nxt;
                        if (m_axi_rlast) begin
                            done_q <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = (state == IDLE) && !axi_areset;
    assign done      = done_q;
    assign done_resp = resp_q;

    assign m_axi_awid     = ID_WIDTH'(TXN_ID);
    assign m_axi_awaddr   = addr_q;
    assign m_axi_awlen    = len_q;
    assign m_axi_awsize   = 3'(SIZE);
    assign m_axi_awburst  = 2'b01;
    assign m_axi_awlock   = 1'b0;
    assign m_axi_awcache  = 4'd0;
    assign m_axi_awprot   = 3'd0;
    assign m_axi_awqos    = 4'd0;
    assign m_axi_awregion = 4'd0;
    assign m_axi_awvalid  = aw_vld_q;

    // Data beats are gated by state so an async reset drops them without waiting for a clock.
    assign m_axi_wdata  = wr_tdata;
    assign m_axi_wstrb  = '1;
    assign m_axi_wvalid = (state == WDATA) && wr_tvalid;
    assign m_axi_wlast  = (state == WDATA) && (beat_cnt == len_q);
    assign wr_tready    = (state == WDATA) && m_axi_wready;

    assign m_axi_bready = (state == WRESP);

    assign m_axi_arid     = ID_WIDTH'(TXN_ID);
    assign m_axi_araddr   = addr_q;
    assign m_axi_arlen    = len_q;
    assign m_axi_arsize   = 3'(SIZE);
    assign m_axi_arburst  = 2'b01;
    assign m_axi_arlock   = 1'b0;
    assign m_axi_arcache  = 4'd0;
    assign m_axi_arprot   = 3'd0;
    assign m_axi_arqos    = 4'd0;
    assign m_axi_arregion = 4'd0;
    assign m_axi_arvalid  = ar_vld_q;

    assign rd_tvalid    = (state == RDATA) && m_axi_rvalid;
    assign rd_tdata     = m_axi_rdata;
    assign rd_tlast     = (state == RDATA) && m_axi_rlast;
    assign m_axi_rready = (state == RDATA) && rd_tready;

    // Single outstanding transaction with a fixed ID, so returned IDs carry no information.
    assign unused_ids = ^{m_axi_bid, m_axi_rid};

endmodule

// File: doc/axi4_burst_master.md
AXI4_BURST_MASTER -- requirements
Module: axi4_burst_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128: AXI4 data width; legal values 32..1024, power of 2.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: AXI4 address width.
REQ-003 SHALL have parameter ID_WIDTH, default 4: AXI4 ID width.
REQ-004 SHALL have parameter TXN_ID, default 0: ID driven on awid/arid.
REQ-005 SHALL have port axi_aclk, input, 1: single clock for all logic.
REQ-006 SHALL have port axi_areset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port cmd_valid / cmd_ready, input / output, 1 each: command handshake.
REQ-008 SHALL have port cmd_write, input, 1: 1 = write burst, 0 = read burst.
REQ-009 SHALL have port cmd_addr, input, ADDR_WIDTH: start byte address, aligned to DATA_WIDTH/8.
REQ-010 SHALL have port cmd_len, input, 8: beats minus 1 (0..255).
REQ-011 SHALL have ports wr_tvalid / wr_tready / wr_tdata, in / out / in, 1/1/DATA_WIDTH: write-data stream.
REQ-012 SHALL have ports rd_tvalid / rd_tready / rd_tdata / rd_tlast, out / in / out / out, 1/1/DATA_WIDTH/1: read-data stream.
REQ-013 SHALL have ports done, output, 1, and done_resp, output, 2: one-cycle completion pulse and worst-case response.
REQ-014 SHALL have the full AXI4 master port set m_axi_aw*, m_axi_w*, m_axi_b*, m_axi_ar*, m_axi_r* at the widths above.

Function
REQ-015 SHALL drive constant tie-offs: awburst/arburst = 2'b01 (INCR); awsize/arsize = clog2(DATA_WIDTH/8); lock/cache/prot/qos/region = 0; wstrb = all ones.
REQ-016 SHALL assert cmd_ready only in IDLE; a command is accepted on cmd_valid && cmd_ready, and its fields are registered.
REQ-017 SHALL implement states IDLE, ADDR, WDATA, WRESP, RDATA, DONE.
REQ-018 SHALL transition IDLE -> ADDR on accept; ADDR -> WDATA (write) or RDATA (read) on the aw/ar handshake; WDATA -> WRESP on the wlast handshake; WRESP -> DONE on bvalid && bready; RDATA -> DONE on the rlast handshake; DONE -> IDLE after one cycle.
REQ-019 SHALL, in ADDR, hold awvalid/arvalid high with stable addr and awlen/arlen = cmd_len until ready; address latency from accept is 1 cycle.
REQ-020 SHALL issue no W beat before the AW handshake completes.
REQ-021 SHALL drive wvalid = wr_tvalid and wr_tready = wready in WDATA, with wdata = wr_tdata combinationally.
REQ-022 SHALL use an 8-bit beat counter incremented per handshake and assert wlast when counter == cmd_len.
REQ-023 SHALL drive bready = 1 in WRESP only.
REQ-024 SHALL drive rd_tvalid = rvalid, rready = rd_tready, rd_tdata = rdata, and rd_tlast = rlast in RDATA.
REQ-025 SHALL accumulate done_resp as the maximum bresp/rresp seen in the transaction; done_resp is valid while done = 1.
REQ-026 SHALL NOT issue a command whose burst crosses a 4 KB boundary (addr[11:0] + (cmd_len+1)*DATA_WIDTH/8 > 4096); it goes IDLE -> DONE with done_resp = 2'b10.
REQ-027 SHALL set done_resp = 2'b10 when rlast arrives with counter != cmd_len, or when counter == cmd_len without rlast; the remaining beats are still drained until rlast.
REQ-028 SHALL support one outstanding transaction only; a back-to-back command is accepted no earlier than the cycle after done.

Reset
REQ-029 SHALL, on axi_areset = 1, asynchronously force state IDLE and deassert all valid/ready/last/done outputs, zero the counter and done_resp, and drive cmd_ready = 0 while reset is held.
REQ-030 SHALL abandon any transaction in progress when reset occurs mid-burst, with no further AXI activity until a new command is accepted.

Verification
REQ-031 Write: addr 0x1000, len 3, slave always ready -> 4 W beats, wlast on the 4th, done one cycle after B with done_resp = 0.
REQ-032 Read: addr 0x2000, len 0, rd_tready toggling 1/0 -> a single beat with rd_tlast = 1, data passed unmodified, done_resp = 0.
REQ-033 4 KB crossing: addr 0x0FF0, len 1, DATA_WIDTH 128 -> no arvalid, done after 1 cycle with done_resp = 2'b10.
REQ-034 Early rlast: len 3, slave asserts rlast on beat 2 -> done_resp = 2'b10, return to IDLE.
REQ-035 Reset mid-write: assert axi_areset after beat 2 of len 7 -> wvalid/awvalid fall without a clock edge; the next command completes normally.
REQ-036 Slave error: bresp = 2'b11 -> done_resp = 2'b11.
